elastic_pipe_stage: RTL and testbench

ELASTIC_PIPE_STAGE -- requirements
Module: elastic_pipe_stage

---
 rtl/elastic_pipe_stage_if.sv | 25 ++
 rtl/elastic_pipe_stage.sv | 103 ++++++++++
 tb/tb_elastic_pipe_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_stage_if.sv
// Valid/ready handshake bundle for elastic_pipe_stage: upstream in_* side and downstream out_* side.
// The stage connects through the slave modport; the producer/consumer environment uses master.
interface elastic_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/elastic_pipe_stage.sv
// Elastic pipeline register between two valid/ready stages, with optional skid entry,
// synchronous flush and a saturating backpressure stall counter.
module elastic_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    elastic_pipe_stage_if.slave  pipe,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    // State encoding doubles as the entry count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              in_ready_q;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic [DATA_W-1:0] head_data, skid_data;
    logic              out_valid, in_ready, in_fire, out_fire;
    logic              load_head_in, load_head_skid, load_skid;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | pipe.out_ready);
    assign in_fire   = pipe.in_valid & in_ready;
    assign out_fire  = out_valid & pipe.out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: if (in_fire) begin
                state_nxt    = ONE;
                load_head_in = 1'b1;
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_head_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end else if (in_fire && SKID != 0) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: if (out_fire) begin
                state_nxt      = ONE;
                load_head_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            head_ctrl  <= '0;
            head_data  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (load_head_in) begin
                head_ctrl <= pipe.in_ctrl;
                head_data <= pipe.in_data;
            end else if (load_head_skid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end
        end
    end

    // NOTE: the skid payload has no reset; it is only ever observed after state says it is valid.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_ctrl <= pipe.in_ctrl;
            skid_data <= pipe.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !pipe.out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign pipe.in_ready  = in_ready;
    assign pipe.out_valid = out_valid;
    assign pipe.out_ctrl  = out_valid ? head_ctrl : '0;
    assign pipe.out_data  = head_data;
    assign occupancy      = state;
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Drives three stage variants (default, 4-bit stall counter, no skid) from one stimulus stream
// and compares each against a bounded-FIFO reference model every cycle.
module tb_elastic_pipe_stage;
    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset, flush, iv, ordy;
    logic [15:0] ictrl;
    logic [31:0] idata;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    elastic_pipe_stage_if #(.DATA_W(32), .CTRL_W(16)) p0 ();
    elastic_pipe_stage_if #(.DATA_W(32), .CTRL_W(16)) p1 ();
    elastic_pipe_stage_if #(.DATA_W(32), .CTRL_W(16)) p2 ();

    logic        o_valid [3];
    logic        o_ready [3];
    logic [15:0] o_ctrl  [3];
    logic [31:0] o_data  [3];
    logic [1:0]  o_occ   [3];
    logic [15:0] o_stall [3];
    logic [3:0]  st1;

    elastic_pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .pipe(p0),
        .occupancy(o_occ[0]), .stall_cnt(o_stall[0]));
    elastic_pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .pipe(p1),
        .occupancy(o_occ[1]), .stall_cnt(st1));
    elastic_pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .flush(flush), .pipe(p2),
        .occupancy(o_occ[2]), .stall_cnt(o_stall[2]));

    assign o_stall[1] = {12'd0, st1};

    assign p0.in_valid = iv;  assign p0.in_ctrl = ictrl;  assign p0.in_data = idata;  assign p0.out_ready = ordy;
    assign p1.in_valid = iv;  assign p1.in_ctrl = ictrl;  assign p1.in_data = idata;  assign p1.out_ready = ordy;
    assign p2.in_valid = iv;  assign p2.in_ctrl = ictrl;  assign p2.in_data = idata;  assign p2.out_ready = ordy;

    assign o_valid[0] = p0.out_valid;  assign o_ready[0] = p0.in_ready;
    assign o_ctrl[0]  = p0.out_ctrl;   assign o_data[0]  = p0.out_data;
    assign o_valid[1] = p1.out_valid;  assign o_ready[1] = p1.in_ready;
    assign o_ctrl[1]  = p1.out_ctrl;   assign o_data[1]  = p1.out_data;
    assign o_valid[2] = p2.out_valid;  assign o_ready[2] = p2.in_ready;
    assign o_ctrl[2]  = p2.out_ctrl;   assign o_data[2]  = p2.out_data;

    // Reference model: an in-order FIFO of capacity 2 (skid) or 1 (no skid) per variant.
    entry_t mbuf [3][2];
    int     mcnt [3] = '{0, 0, 0};
    int     mst  [3] = '{0, 0, 0};

    function automatic logic m_in_ready(input int i);
        if (i != 2) return (mcnt[i] < 2);
        return (mcnt[i] == 0) || ordy;
    endfunction

    function automatic int m_max(input int i);
        return (i == 1) ? 15 : 65535;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d out_valid", i), 64'(o_valid[i]), 64'(mcnt[i] != 0));
            check($sformatf("d%0d occupancy", i), 64'(o_occ[i]), 64'(mcnt[i]));
            check($sformatf("d%0d in_ready", i), 64'(o_ready[i]), 64'(m_in_ready(i)));
            check($sformatf("d%0d stall_cnt", i), 64'(o_stall[i]), 64'(mst[i]));
            check($sformatf("d%0d out_ctrl", i), 64'(o_ctrl[i]),
                  (mcnt[i] != 0) ? 64'(mbuf[i][0].ctrl) : 64'd0);
            if (mcnt[i] != 0)
                check($sformatf("d%0d out_data", i), 64'(o_data[i]), 64'(mbuf[i][0].data));
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic mir, ov;
            mir = m_in_ready(i);
            ov  = (mcnt[i] != 0);
            if (reset) begin
                mcnt[i] = 0;
                mst[i]  = 0;
            end else begin
                if (ov && !ordy && mst[i] < m_max(i)) mst[i]++;
                if (flush) begin
                    mcnt[i] = 0;
                end else begin
                    if (ov && ordy) begin
                        mbuf[i][0] = mbuf[i][1];
                        mcnt[i]--;
                    end
                    if (iv && mir) begin
                        mbuf[i][mcnt[i]] = '{ctrl: ictrl, data: idata};
                        mcnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] d, input logic rd);
        reset = r;
        flush = f;
        iv    = v;
        ictrl = d[15:0] ^ 16'h5a00;
        idata = d;
        ordy  = rd;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ab();
        drive(1, 0, 0, 0, 0);         cycle();
        drive(0, 0, 1, 32'hA, 0);     cycle();
        drive(0, 0, 1, 32'hB, 0);     cycle();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("d%0d reset out_data", i), 64'(o_data[i]), 64'd0);
        check("reset in_ready", 64'(o_ready[0]), 64'd1);
        check("reset stall", 64'(o_stall[0]), 64'd0);
        cycle();

        // Streaming: 1..8 back to back.
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 32'(k), 1);
            cycle();
            check("stream data", 64'(o_data[0]), 64'(k));
            check("stream occ", 64'(o_occ[0]), 64'd1);
        end
        drive(0, 0, 0, 0, 1);
        cycle(); cycle();

        // Backpressure: A, B fill the stage, C waits upstream.
        fill_ab();
        drive(0, 0, 1, 32'hC, 0);     cycle();
        check("bp full occ", 64'(o_occ[0]), 64'd2);
        check("bp full in_ready", 64'(o_ready[0]), 64'd0);
        cycle();
        drive(0, 0, 1, 32'hC, 1);     cycle();
        check("bp head B", 64'(o_data[0]), 64'hB);
        cycle();
        check("bp head C", 64'(o_data[0]), 64'hC);
        drive(0, 0, 0, 0, 1);         cycle();
        check("bp drained", 64'(o_valid[0]), 64'd0);
        check("bp stall", 64'(o_stall[0]), 64'd3);

        // Flush in FULL with a new entry offered.
        fill_ab();
        drive(0, 1, 1, 32'hD, 0);     cycle();
        check("flush occ", 64'(o_occ[0]), 64'd0);
        check("flush valid", 64'(o_valid[0]), 64'd0);
        check("flush ctrl", 64'(o_ctrl[0]), 64'd0);
        check("flush in_ready", 64'(o_ready[0]), 64'd1);
        drive(0, 0, 0, 0, 1);
        cycle(); cycle();
        check("flush D dropped", 64'(o_valid[0]), 64'd0);

        // Reset in FULL with stall_cnt at 5.
        fill_ab();
        drive(0, 0, 0, 0, 0);
        repeat (4) cycle();
        check("pre-reset stall", 64'(o_stall[0]), 64'd5);
        check("pre-reset occ", 64'(o_occ[0]), 64'd2);
        drive(1, 1, 1, 32'hE, 1);     cycle();
        check("rst valid", 64'(o_valid[0]), 64'd0);
        check("rst occ", 64'(o_occ[0]), 64'd0);
        check("rst in_ready", 64'(o_ready[0]), 64'd1);
        check("rst ctrl", 64'(o_ctrl[0]), 64'd0);
        check("rst data", 64'(o_data[0]), 64'd0);
        check("rst stall", 64'(o_stall[0]), 64'd0);

        // Saturation: 20 stalled cycles.
        drive(0, 0, 1, 32'h77, 0);    cycle();
        drive(0, 0, 0, 0, 0);
        repeat (20) cycle();
        check("sat stall 4b", 64'(o_stall[1]), 64'd15);
        check("sat stall 16b", 64'(o_stall[0]), 64'd20);
        drive(0, 0, 0, 0, 1);         cycle();

        // No-skid variant under a toggling out_ready.
        drive(1, 0, 0, 0, 0);         cycle();
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 1, 32'h100 + 32'(k), k[0]);
            cycle();
            check("skid0 occ<=1", 64'(o_occ[2] <= 2'd1), 64'd1);
        end

        // Random traffic with occasional flush and reset.
        drive(1, 0, 0, 0, 0);         cycle();
        repeat (600) begin
            drive(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                  $urandom, ($urandom % 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
